// File: rtl/imem_arbiter_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | imem_pkg                                                              |
// | Shared types and defaults for the instruction-memory arbiter.         |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
package imem_pkg;

    localparam int IMEM_DEPTH = 16;

    typedef enum logic {
        ARB    = 1'b0,
        LOCKED = 1'b1
    } imem_arb_state_t;

    typedef enum logic {
        OWN_FETCH = 1'b0,
        OWN_LOAD  = 1'b1
    } imem_owner_t;

endpackage
`default_nettype wire

// File: rtl/imem_arbiter_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | imem_arbiter_if                                                       |
// | Fetch, loader and RAM-side signal bundle for imem_arbiter.            |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
interface imem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DEPTH  = 16
);
    localparam int IDX_W = $clog2(DEPTH);

    logic              fetch_req_valid;
    logic              fetch_req_ready;
    logic [ADDR_W-1:0] fetch_addr;
    logic              fetch_flush;
    logic              fetch_rsp_valid;
    logic [31:0]       fetch_rsp_data;
    logic              fetch_rsp_err;

    logic              load_req_valid;
    logic              load_req_ready;
    logic              load_we;
    logic              load_lock;
    logic [ADDR_W-1:0] load_addr;
    logic [31:0]       load_wdata;
    logic              load_rsp_valid;
    logic [31:0]       load_rsp_data;
    logic              load_rsp_err;

    logic              mem_en;
    logic              mem_we;
    logic [IDX_W-1:0]  mem_idx;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;

    // Arbiter side.
    modport slave (
        input  fetch_req_valid, fetch_addr, fetch_flush,
        input  load_req_valid, load_we, load_lock, load_addr, load_wdata,
        input  mem_rdata,
        output fetch_req_ready, fetch_rsp_valid, fetch_rsp_data, fetch_rsp_err,
        output load_req_ready, load_rsp_valid, load_rsp_data, load_rsp_err,
        output mem_en, mem_we, mem_idx, mem_wdata
    );

    // Requesters plus RAM side.
    modport master (
        output fetch_req_valid, fetch_addr, fetch_flush,
        output load_req_valid, load_we, load_lock, load_addr, load_wdata,
        output mem_rdata,
        input  fetch_req_ready, fetch_rsp_valid, fetch_rsp_data, fetch_rsp_err,
        input  load_req_ready, load_rsp_valid, load_rsp_data, load_rsp_err,
        input  mem_en, mem_we, mem_idx, mem_wdata
    );

endinterface
`default_nettype wire

// File: rtl/imem_arbiter_rr_pick.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | imem_rr_pick                                                          |
// | Two-way round-robin pick between fetch and loader requests.           |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module imem_rr_pick
    import imem_pkg::*;
(
    input  wire logic  i_req_fetch,
    input  wire logic  i_req_load,
    input  imem_owner_t i_last_grant,
    output logic       o_grant_fetch,
    output logic       o_grant_load
);

    always_comb begin
        o_grant_fetch = 1'b0;
        o_grant_load  = 1'b0;
        if (i_req_fetch && i_req_load) begin
            // On a tie the side that did not win last time goes first.
            if (i_last_grant == OWN_FETCH) begin
                o_grant_load = 1'b1;
            end else begin
                o_grant_fetch = 1'b1;
            end
        end else begin
            o_grant_fetch = i_req_fetch;
            o_grant_load  = i_req_load;
        end
    end

endmodule
`default_nettype wire

// File: rtl/imem_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | imem_arbiter                                                          |
// | Shares a single-port instruction RAM between fetch and the loader.    |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module imem_arbiter
    import imem_pkg::*;
#(
    parameter int DEPTH  = IMEM_DEPTH,
    parameter int ADDR_W = 32
) (
    input  wire logic     clk,
    input  wire logic     reset,
    imem_arbiter_if.slave bus
);

    localparam int                c_IDX_W = $clog2(DEPTH);
    localparam logic [ADDR_W-1:0] c_DEPTH = ADDR_W'(DEPTH);

    imem_arb_state_t    r_state;
    imem_arb_state_t    w_state_nxt;
    imem_owner_t        r_last_grant;
    imem_owner_t        r_rsp_owner;
    logic               r_rsp_pending;
    logic               r_rsp_err;
    logic               r_rsp_we;

    logic               w_grant_fetch;
    logic               w_grant_load;
    logic               w_fetch_ready;
    logic               w_load_ready;
    logic               w_fetch_hs;
    logic               w_load_hs;
    logic               w_fetch_in_range;
    logic               w_load_in_range;

    logic               w_mem_en;
    logic               w_mem_we;
    logic [c_IDX_W-1:0] w_mem_idx;
    logic [31:0]        w_mem_wdata;
    logic               w_acc_err;

    logic               w_fetch_rsp;
    logic               w_load_rsp;
    logic [31:0]        w_rsp_data;

    assign w_fetch_in_range = (bus.fetch_addr >> 2) < c_DEPTH;
    assign w_load_in_range  = (bus.load_addr  >> 2) < c_DEPTH;

    imem_rr_pick u_pick (
        .i_req_fetch   (bus.fetch_req_valid),
        .i_req_load    (bus.load_req_valid),
        .i_last_grant  (r_last_grant),
        .o_grant_fetch (w_grant_fetch),
        .o_grant_load  (w_grant_load)
    );

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ARB;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ARB: begin
                if (w_load_hs && bus.load_lock) begin
                    w_state_nxt = LOCKED;
                end
            end
            LOCKED: begin
                if (!bus.load_lock) begin
                    w_state_nxt = ARB;
                end
            end
            default: w_state_nxt = ARB;
        endcase
    end

    // State outputs: ready strobes, held low throughout reset.
    always_comb begin
        w_fetch_ready = 1'b0;
        w_load_ready  = 1'b0;
        if (!reset) begin
            case (r_state)
                ARB: begin
                    w_fetch_ready = w_grant_fetch;
                    w_load_ready  = w_grant_load;
                end
                LOCKED: begin
                    w_load_ready  = 1'b1;
                end
                default: begin
                    w_fetch_ready = 1'b0;
                    w_load_ready  = 1'b0;
                end
            endcase
        end
    end

    assign w_fetch_hs = bus.fetch_req_valid && w_fetch_ready;
    assign w_load_hs  = bus.load_req_valid  && w_load_ready;

    // RAM strobes; out-of-range accesses are accepted but never reach the RAM.
    always_comb begin
        w_mem_en    = 1'b0;
        w_mem_we    = 1'b0;
        w_mem_idx   = '0;
        w_mem_wdata = '0;
        w_acc_err   = 1'b0;
        if (w_load_hs) begin
            w_mem_en    = w_load_in_range;
            w_mem_we    = w_load_in_range && bus.load_we;
            w_mem_idx   = bus.load_addr[c_IDX_W+1:2];
            w_mem_wdata = bus.load_wdata;
            w_acc_err   = !w_load_in_range;
        end else if (w_fetch_hs) begin
            w_mem_en    = w_fetch_in_range;
            w_mem_idx   = bus.fetch_addr[c_IDX_W+1:2];
            w_acc_err   = !w_fetch_in_range;
        end
    end

    assign bus.mem_en    = w_mem_en;
    assign bus.mem_we    = w_mem_we;
    assign bus.mem_idx   = w_mem_idx;
    assign bus.mem_wdata = w_mem_wdata;

    // Tracking of the single access in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rsp_pending <= 1'b0;
            r_rsp_owner   <= OWN_FETCH;
            r_rsp_err     <= 1'b0;
            r_rsp_we      <= 1'b0;
            r_last_grant  <= OWN_FETCH;
        end else begin
            r_rsp_pending <= w_fetch_hs || w_load_hs;
            if (w_fetch_hs || w_load_hs) begin
                r_rsp_owner  <= w_load_hs ? OWN_LOAD : OWN_FETCH;
                r_last_grant <= w_load_hs ? OWN_LOAD : OWN_FETCH;
                r_rsp_err    <= w_acc_err;
                r_rsp_we     <= w_load_hs && bus.load_we;
            end
        end
    end

    assign w_fetch_rsp = r_rsp_pending && (r_rsp_owner == OWN_FETCH) && !bus.fetch_flush;
    assign w_load_rsp  = r_rsp_pending && (r_rsp_owner == OWN_LOAD);
    assign w_rsp_data  = (r_rsp_err || r_rsp_we) ? 32'h0 : bus.mem_rdata;

    assign bus.fetch_req_ready = w_fetch_ready;
    assign bus.fetch_rsp_valid = w_fetch_rsp;
    assign bus.fetch_rsp_data  = w_rsp_data;
    assign bus.fetch_rsp_err   = w_fetch_rsp && r_rsp_err;

    assign bus.load_req_ready  = w_load_ready;
    assign bus.load_rsp_valid  = w_load_rsp;
    assign bus.load_rsp_data   = w_rsp_data;
    assign bus.load_rsp_err    = w_load_rsp && r_rsp_err;

endmodule
`default_nettype wire

// File: tb/tb_imem_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_imem_arbiter                                                       |
// | Directed self-checking bench for imem_arbiter with a 16-word RAM.     |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module tb_imem_arbiter;

    logic clk;
    logic reset;
    int   n_assert;
    int   n_fail;

    imem_arbiter_if #(.ADDR_W(32), .DEPTH(16)) bus ();

    imem_arbiter #(.DEPTH(16), .ADDR_W(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    logic [31:0] ram [16] = '{
        32'hA0A0_0000, 32'hB1B1_0001, 32'h0050_0093, 32'h0000_0003,
        32'h0000_0004, 32'h0000_0005, 32'h0000_0006, 32'h0000_0007,
        32'h0000_0008, 32'h0000_0009, 32'h0000_000A, 32'h0000_000B,
        32'h0000_000C, 32'h0000_000D, 32'h0000_000E, 32'h0000_000F
    };

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous single-port RAM model.
    always @(posedge clk) begin
        if (bus.mem_en) begin
            if (bus.mem_we) ram[bus.mem_idx] <= bus.mem_wdata;
            else            bus.mem_rdata    <= ram[bus.mem_idx];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        bus.fetch_req_valid = 1'b0;
        bus.fetch_addr      = '0;
        bus.fetch_flush     = 1'b0;
        bus.load_req_valid  = 1'b0;
        bus.load_we         = 1'b0;
        bus.load_lock       = 1'b0;
        bus.load_addr       = '0;
        bus.load_wdata      = '0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic fetch(input logic [31:0] a);
        bus.fetch_req_valid = 1'b1;
        bus.fetch_addr      = a;
    endtask

    task automatic load(input logic we, input logic lk, input logic [31:0] a, input logic [31:0] d);
        bus.load_req_valid = 1'b1;
        bus.load_we        = we;
        bus.load_lock      = lk;
        bus.load_addr      = a;
        bus.load_wdata     = d;
    endtask

    initial begin
        n_assert = 0;
        n_fail   = 0;
        bus.mem_rdata = '0;
        idle();
        reset = 1'b1;
        fetch(32'h8);
        load(1'b0, 1'b0, 32'h4, 32'h0);
        #12;
        chk("rst_fetch_ready", {31'h0, bus.fetch_req_ready}, 32'h0);
        chk("rst_load_ready",  {31'h0, bus.load_req_ready},  32'h0);
        chk("rst_mem_en",      {31'h0, bus.mem_en},          32'h0);
        chk("rst_fetch_rsp",   {31'h0, bus.fetch_rsp_valid}, 32'h0);
        chk("rst_load_rsp",    {31'h0, bus.load_rsp_valid},  32'h0);
        next_cycle();
        reset = 1'b0;
        idle();

        // Basic fetch of word 2.
        next_cycle(); fetch(32'h8); #1;
        chk("f8_ready",  {31'h0, bus.fetch_req_ready}, 32'h1);
        chk("f8_mem_en", {31'h0, bus.mem_en},          32'h1);
        chk("f8_idx",    {28'h0, bus.mem_idx},         32'h2);
        next_cycle(); idle(); #1;
        chk("f8_rsp_valid", {31'h0, bus.fetch_rsp_valid}, 32'h1);
        chk("f8_rsp_data",  bus.fetch_rsp_data,           32'h0050_0093);
        chk("f8_rsp_err",   {31'h0, bus.fetch_rsp_err},   32'h0);

        // Both requesting: LOAD, FETCH, LOAD, FETCH.
        next_cycle(); fetch(32'h0); load(1'b0, 1'b0, 32'h4, 32'h0); #1;
        chk("rr1_load_ready",  {31'h0, bus.load_req_ready},  32'h1);
        chk("rr1_fetch_ready", {31'h0, bus.fetch_req_ready}, 32'h0);
        next_cycle(); #1;
        chk("rr2_fetch_ready", {31'h0, bus.fetch_req_ready}, 32'h1);
        chk("rr2_load_rsp",    {31'h0, bus.load_rsp_valid},  32'h1);
        chk("rr2_load_data",   bus.load_rsp_data,            32'hB1B1_0001);
        chk("rr2_fetch_rsp",   {31'h0, bus.fetch_rsp_valid}, 32'h0);
        next_cycle(); #1;
        chk("rr3_load_ready",  {31'h0, bus.load_req_ready},  32'h1);
        chk("rr3_fetch_rsp",   {31'h0, bus.fetch_rsp_valid}, 32'h1);
        chk("rr3_fetch_data",  bus.fetch_rsp_data,           32'hA0A0_0000);
        next_cycle(); #1;
        chk("rr4_fetch_ready", {31'h0, bus.fetch_req_ready}, 32'h1);
        chk("rr4_load_rsp",    {31'h0, bus.load_rsp_valid},  32'h1);
        chk("rr4_load_data",   bus.load_rsp_data,            32'hB1B1_0001);
        next_cycle(); idle(); #1;
        chk("rr5_fetch_rsp",   {31'h0, bus.fetch_rsp_valid}, 32'h1);
        chk("rr5_fetch_data",  bus.fetch_rsp_data,           32'hA0A0_0000);
        chk("rr5_load_rsp",    {31'h0, bus.load_rsp_valid},  32'h0);

        // Locked write of 0xDEADBEEF to word 15 while fetch waits.
        next_cycle(); fetch(32'h3C); load(1'b1, 1'b1, 32'h3C, 32'hDEAD_BEEF); #1;
        chk("lk_load_ready",  {31'h0, bus.load_req_ready},  32'h1);
        chk("lk_fetch_ready", {31'h0, bus.fetch_req_ready}, 32'h0);
        chk("lk_mem_we",      {31'h0, bus.mem_we},          32'h1);
        chk("lk_mem_idx",     {28'h0, bus.mem_idx},         32'hF);
        chk("lk_mem_wdata",   bus.mem_wdata,                32'hDEAD_BEEF);
        next_cycle(); bus.load_req_valid = 1'b0; #1;
        chk("lk1_fetch_ready", {31'h0, bus.fetch_req_ready}, 32'h0);
        chk("lk1_load_rsp",    {31'h0, bus.load_rsp_valid},  32'h1);
        chk("lk1_load_data",   bus.load_rsp_data,            32'h0);
        chk("lk1_load_err",    {31'h0, bus.load_rsp_err},    32'h0);
        next_cycle(); #1;
        chk("lk2_fetch_ready", {31'h0, bus.fetch_req_ready}, 32'h0);
        next_cycle(); bus.load_lock = 1'b0; #1;
        chk("lk3_fetch_ready", {31'h0, bus.fetch_req_ready}, 32'h0);
        next_cycle(); #1;
        chk("lk4_fetch_ready", {31'h0, bus.fetch_req_ready}, 32'h1);
        chk("lk4_mem_idx",     {28'h0, bus.mem_idx},         32'hF);
        next_cycle(); idle(); #1;
        chk("lk5_fetch_rsp",  {31'h0, bus.fetch_rsp_valid}, 32'h1);
        chk("lk5_fetch_data", bus.fetch_rsp_data,           32'hDEAD_BEEF);

        // Out-of-range fetch.
        next_cycle(); fetch(32'h40); #1;
        chk("oor_ready",  {31'h0, bus.fetch_req_ready}, 32'h1);
        chk("oor_mem_en", {31'h0, bus.mem_en},          32'h0);
        next_cycle(); idle(); #1;
        chk("oor_rsp_valid", {31'h0, bus.fetch_rsp_valid}, 32'h1);
        chk("oor_rsp_data",  bus.fetch_rsp_data,           32'h0);
        chk("oor_rsp_err",   {31'h0, bus.fetch_rsp_err},   32'h1);

        // Flushed response, second fetch in the flush cycle still answers.
        next_cycle(); fetch(32'h8); #1;
        chk("fl_ready", {31'h0, bus.fetch_req_ready}, 32'h1);
        next_cycle(); fetch(32'h4); bus.fetch_flush = 1'b1; #1;
        chk("fl_rsp_valid", {31'h0, bus.fetch_rsp_valid}, 32'h0);
        chk("fl_ready2",    {31'h0, bus.fetch_req_ready}, 32'h1);
        next_cycle(); idle(); #1;
        chk("fl2_rsp_valid", {31'h0, bus.fetch_rsp_valid}, 32'h1);
        chk("fl2_rsp_data",  bus.fetch_rsp_data,           32'hB1B1_0001);

        // Reset with a loader read in flight.
        next_cycle(); load(1'b0, 1'b0, 32'h8, 32'h0); #1;
        chk("rs_load_ready", {31'h0, bus.load_req_ready}, 32'h1);
        next_cycle(); reset = 1'b1; #1;
        chk("rs_load_rsp",  {31'h0, bus.load_rsp_valid}, 32'h0);
        chk("rs_load_err",  {31'h0, bus.load_rsp_err},   32'h0);
        chk("rs_ready",     {31'h0, bus.load_req_ready}, 32'h0);
        chk("rs_mem_en",    {31'h0, bus.mem_en},         32'h0);
        next_cycle(); reset = 1'b0; idle(); #1;
        chk("rs2_load_rsp", {31'h0, bus.load_rsp_valid}, 32'h0);
        next_cycle(); fetch(32'h0); load(1'b0, 1'b0, 32'h4, 32'h0); #1;
        chk("rs3_load_ready",  {31'h0, bus.load_req_ready},  32'h1);
        chk("rs3_fetch_ready", {31'h0, bus.fetch_req_ready}, 32'h0);
        next_cycle(); #1;
        chk("rs4_fetch_ready", {31'h0, bus.fetch_req_ready}, 32'h1);
        chk("rs4_load_data",   bus.load_rsp_data,            32'hB1B1_0001);
        next_cycle(); idle(); #1;
        chk("rs5_fetch_rsp",  {31'h0, bus.fetch_rsp_valid}, 32'h1);
        chk("rs5_fetch_data", bus.fetch_rsp_data,           32'hA0A0_0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
